// File: rtl/arc4_prga_pkg.sv
// ARC4 PRGA shared definitions.
//   prga_state_t  : controller state encoding
//   PRINT_*_DEF   : default printable-byte window
//   is_printable  : inclusive window test used on every plaintext byte
package arc4_prga_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_LEN,
      ST_WAIT_LEN,
      ST_WR_LEN,
      ST_RD_SI,
      ST_WAIT_SI,
      ST_RD_SJ,
      ST_WAIT_SJ,
      ST_WR_SI,
      ST_WR_SJ,
      ST_RD_PAD,
      ST_WAIT_PAD,
      ST_WR_PT,
      ST_DONE
   } prga_state_t;

   localparam logic [7:0] PRINT_LO_DEF = 8'h20;
   localparam logic [7:0] PRINT_HI_DEF = 8'h7E;

   function automatic logic is_printable(input logic [7:0] b,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
      return (b >= lo) && (b <= hi);
   endfunction

endpackage

// File: rtl/arc4_prga_if.sv
// ARC4 PRGA bus bundle: start handshake plus the S, ciphertext and
// plaintext memory ports.
//   slave  : the PRGA engine (takes en and read data, drives everything else)
//   master : the surrounding core / memories
interface arc4_prga_if;
   logic       en;
   logic       rdy;
   logic       invalid;
   logic [7:0] s_addr;
   logic [7:0] s_rddata;
   logic [7:0] s_wrdata;
   logic       s_wren;
   logic [7:0] ct_addr;
   logic [7:0] ct_rddata;
   logic [7:0] pt_addr;
   logic [7:0] pt_wrdata;
   logic       pt_wren;

   modport slave (
      input  en, s_rddata, ct_rddata,
      output rdy, invalid, s_addr, s_wrdata, s_wren,
             ct_addr, pt_addr, pt_wrdata, pt_wren
   );

   modport master (
      output en, s_rddata, ct_rddata,
      input  rdy, invalid, s_addr, s_wrdata, s_wren,
             ct_addr, pt_addr, pt_wrdata, pt_wren
   );
endinterface

// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation + decrypt stage.
// Walks the length-prefixed ciphertext, performs the PRGA swap on S for each
// byte, XORs the pad into the ciphertext and writes the length-prefixed
// plaintext. Flags any non-printable plaintext byte.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : arc4_prga_if.slave (en/rdy/invalid, S, ct and pt memory ports)
// All memories have one cycle of read latency; each read state is followed by
// a wait state that holds the address so read data is valid in the next state.
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | rdy=1, waiting for en
// RD_LEN      | present ct[0]
// WAIT_LEN    | hold ct[0]
// WR_LEN      | latch len, write pt[0], k=1, j=0
// RD_SI       | i=k, present s[i]
// WAIT_SI     | hold s[i]
// RD_SJ       | latch si, j+=si, present s[j]
// WAIT_SJ     | hold s[j]
// WR_SI       | latch sj, s[i]<=sj
// WR_SJ       | s[j]<=si
// RD_PAD      | present s[si+sj] and ct[k]
// WAIT_PAD    | hold pad / ct addresses
// WR_PT       | pt[k]<=pad^ct, printability check, loop or finish
// DONE        | one cycle before returning to IDLE
module arc4_prga
   import arc4_prga_pkg::*;
#(
   parameter bit         ABORT_ON_INVALID = 1'b1,
   parameter logic [7:0] PRINT_LO         = PRINT_LO_DEF,
   parameter logic [7:0] PRINT_HI         = PRINT_HI_DEF
) (
   input  logic        clk,
   input  logic        rst,
   arc4_prga_if.slave  bus
);

   prga_state_t state, state_nxt;
   logic [7:0]  i, j, k, len, si, sj;
   logic        invalid_q;

   logic [7:0]  pt_byte;
   logic        byte_bad;
   logic        last_byte;

   assign pt_byte   = bus.s_rddata ^ bus.ct_rddata;
   assign byte_bad  = !is_printable(pt_byte, PRINT_LO, PRINT_HI);
   assign last_byte = ((byte_bad || invalid_q) && ABORT_ON_INVALID) || (k == len);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         len       <= '0;
         si        <= '0;
         sj        <= '0;
         invalid_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE:  if (bus.en) invalid_q <= 1'b0;
            ST_WR_LEN: begin
               len <= bus.ct_rddata;
               k   <= 8'd1;
               j   <= 8'd0;
            end
            ST_RD_SI: i <= k;
            ST_RD_SJ: begin
               si <= bus.s_rddata;
               j  <= j + bus.s_rddata;
            end
            ST_WR_SI: sj <= bus.s_rddata;
            ST_WR_PT: begin
               if (byte_bad) invalid_q <= 1'b1;
               if (!last_byte) k <= k + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Outputs are decoded from state; reset forces them to their idle values
   // in the same cycle so a reset landing on a write state cannot write.
   always_comb begin
      state_nxt     = state;
      bus.rdy       = 1'b0;
      bus.invalid   = invalid_q && !rst;
      bus.s_addr    = 8'd0;
      bus.s_wrdata  = 8'd0;
      bus.s_wren    = 1'b0;
      bus.ct_addr   = 8'd0;
      bus.pt_addr   = 8'd0;
      bus.pt_wrdata = 8'd0;
      bus.pt_wren   = 1'b0;

      case (state)
         ST_IDLE: begin
            bus.rdy = 1'b1;
            if (bus.en) state_nxt = ST_RD_LEN;
         end
         ST_RD_LEN:   state_nxt = ST_WAIT_LEN;
         ST_WAIT_LEN: state_nxt = ST_WR_LEN;
         ST_WR_LEN: begin
            bus.pt_wrdata = bus.ct_rddata;
            bus.pt_wren   = !rst;
            state_nxt     = (bus.ct_rddata == 8'd0) ? ST_DONE : ST_RD_SI;
         end
         ST_RD_SI: begin
            bus.s_addr = k;
            state_nxt  = ST_WAIT_SI;
         end
         ST_WAIT_SI: begin
            bus.s_addr = i;
            state_nxt  = ST_RD_SJ;
         end
         ST_RD_SJ: begin
            bus.s_addr = j + bus.s_rddata;
            state_nxt  = ST_WAIT_SJ;
         end
         ST_WAIT_SJ: begin
            bus.s_addr = j;
            state_nxt  = ST_WR_SI;
         end
         ST_WR_SI: begin
            bus.s_addr   = i;
            bus.s_wrdata = bus.s_rddata;
            bus.s_wren   = !rst;
            state_nxt    = ST_WR_SJ;
         end
         ST_WR_SJ: begin
            bus.s_addr   = j;
            bus.s_wrdata = si;
            bus.s_wren   = !rst;
            state_nxt    = ST_RD_PAD;
         end
         ST_RD_PAD: begin
            bus.s_addr  = si + sj;
            bus.ct_addr = k;
            state_nxt   = ST_WAIT_PAD;
         end
         ST_WAIT_PAD: begin
            bus.s_addr  = si + sj;
            bus.ct_addr = k;
            state_nxt   = ST_WR_PT;
         end
         ST_WR_PT: begin
            bus.pt_addr   = k;
            bus.pt_wrdata = pt_byte;
            bus.pt_wren   = !rst;
            state_nxt     = last_byte ? ST_DONE : ST_RD_SI;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase

      if (rst) begin
         bus.rdy       = 1'b1;
         bus.s_addr    = 8'd0;
         bus.s_wrdata  = 8'd0;
         bus.ct_addr   = 8'd0;
         bus.pt_addr   = 8'd0;
         bus.pt_wrdata = 8'd0;
      end
   end

endmodule

// File: tb/tb_arc4_prga.sv
module tb_arc4_prga;
   import arc4_prga_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arc4_prga_if ia();
   arc4_prga_if ib();

   arc4_prga #(.ABORT_ON_INVALID(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   arc4_prga #(.ABORT_ON_INVALID(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

   // Only one instance runs at a time; the idle one drives zeros, so the
   // memory models see the OR of both.
   logic [7:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
   logic       s_wren, pt_wren;
   logic [7:0] s_rddata, ct_rddata;
   assign s_addr    = ia.s_addr    | ib.s_addr;
   assign s_wrdata  = ia.s_wrdata  | ib.s_wrdata;
   assign s_wren    = ia.s_wren    | ib.s_wren;
   assign ct_addr   = ia.ct_addr   | ib.ct_addr;
   assign pt_addr   = ia.pt_addr   | ib.pt_addr;
   assign pt_wrdata = ia.pt_wrdata | ib.pt_wrdata;
   assign pt_wren   = ia.pt_wren   | ib.pt_wren;
   assign ia.s_rddata  = s_rddata;
   assign ib.s_rddata  = s_rddata;
   assign ia.ct_rddata = ct_rddata;
   assign ib.ct_rddata = ct_rddata;

   logic [7:0] s_mem [256];
   logic [7:0] ct_mem [256];
   logic [7:0] pt_mem [256];
   bit         pt_written [256];

   always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      ct_rddata <= ct_mem[ct_addr];
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      if (pt_wren) begin
         pt_mem[pt_addr]     <= pt_wrdata;
         pt_written[pt_addr] <= 1'b1;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Stimulus image and reference results
   logic [7:0] s_init [256];
   logic [7:0] ct_init [256];
   logic [7:0] ref_s [256];
   bit         ref_inv;
   int         ref_n;
   logic [15:0] exp_q [$];
   int         s_wr_cnt;
   int         last_lat;

   // Software ARC4 PRGA over the message, stopping after the first bad byte
   // when abort is set.
   task automatic model(input bit abrt);
      logic [7:0] ii, jj, t, idx, p, len;
      for (int x = 0; x < 256; x++) ref_s[x] = s_init[x];
      len = ct_init[0];
      exp_q.push_back({8'h00, len});
      jj = 8'd0;
      ref_inv = 1'b0;
      ref_n = 0;
      for (int kk = 1; kk <= int'(len); kk++) begin
         ii = 8'(kk);
         jj = jj + ref_s[ii];
         t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
         idx = ref_s[ii] + ref_s[jj];
         p = ref_s[idx] ^ ct_init[kk];
         exp_q.push_back({ii, p});
         ref_n = kk;
         if (p < 8'h20 || p > 8'h7E) ref_inv = 1'b1;
         if (ref_inv && abrt) break;
      end
   endtask

   task automatic load_mems();
      for (int x = 0; x < 256; x++) begin
         s_mem[x] = s_init[x];
         ct_mem[x] = ct_init[x];
         pt_mem[x] = 8'h00;
         pt_written[x] = 1'b0;
      end
   endtask

   task automatic set_identity();
      for (int x = 0; x < 256; x++) begin
         s_init[x] = 8'(x);
         ct_init[x] = 8'h00;
      end
   endtask

   task automatic set_random(input int len);
      logic [7:0] t;
      int r;
      for (int x = 0; x < 256; x++) begin
         s_init[x] = 8'(x);
         ct_init[x] = 8'($urandom_range(0, 255));
      end
      for (int x = 255; x > 0; x--) begin
         r = $urandom_range(0, x);
         t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
      end
      ct_init[0] = 8'(len);
   endtask

   // Monitor: pops one expected plaintext write per pt_wren pulse.
   always @(negedge clk) begin
      logic [15:0] e;
      if (!rst) begin
         if (s_wren || pt_wren) chk("single_wren", {31'd0, s_wren && pt_wren}, 32'd0);
         if (s_wren) s_wr_cnt++;
         if (pt_wren) begin
            if (exp_q.size() == 0) begin
               chk("pt_unexpected_write", {16'd0, pt_addr, pt_wrdata}, 32'hFFFFFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("pt_write", {16'd0, pt_addr, pt_wrdata}, {16'd0, e});
            end
         end
      end
   end

   // Starts a run on instance A (use_b=0) or B, waits for rdy with a cycle
   // bound, then checks against the model. glitch>0 pulses en at that cycle.
   task automatic run_case(input bit use_b, input string nm, input int glitch);
      int mis;
      load_mems();
      exp_q.delete();
      model(use_b ? 1'b0 : 1'b1);
      s_wr_cnt = 0;
      @(negedge clk);
      chk({nm, "_rdy_before"}, {31'd0, use_b ? ib.rdy : ia.rdy}, 32'd1);
      if (use_b) ib.en = 1'b1; else ia.en = 1'b1;
      @(posedge clk);
      #1;
      ia.en = 1'b0; ib.en = 1'b0;
      last_lat = 0;
      do begin
         @(posedge clk);
         #1;
         last_lat++;
         ia.en = 1'b0; ib.en = 1'b0;
         if (last_lat == glitch) begin
            if (use_b) ib.en = 1'b1; else ia.en = 1'b1;
         end
      end while (!(use_b ? ib.rdy : ia.rdy) && last_lat < 3000);
      ia.en = 1'b0; ib.en = 1'b0;
      chk({nm, "_latency"}, last_lat, 3 + 9 * ref_n + 1);
      chk({nm, "_invalid"}, {31'd0, use_b ? ib.invalid : ia.invalid}, {31'd0, ref_inv});
      @(negedge clk);
      chk({nm, "_pending_writes"}, exp_q.size(), 0);
      mis = 0;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) mis++;
      chk({nm, "_final_s_mismatches"}, mis, 0);
   endtask

   task automatic check_scn2(input string nm);
      chk({nm, "_pt0"}, pt_mem[0], 8'h03);
      chk({nm, "_pt1"}, pt_mem[1], 8'h43);
      chk({nm, "_pt2"}, pt_mem[2], 8'h47);
      chk({nm, "_pt3"}, pt_mem[3], 8'h44);
      chk({nm, "_s2"}, s_mem[2], 8'h03);
      chk({nm, "_s3"}, s_mem[3], 8'h05);
      chk({nm, "_s5"}, s_mem[5], 8'h02);
      chk({nm, "_lat"}, last_lat, 31);
      chk({nm, "_inv"}, {31'd0, ia.invalid}, 32'd0);
   endtask

   initial begin
      int n;
      int len;
      rst = 1'b1;
      ia.en = 1'b0; ib.en = 1'b0;
      set_identity();
      load_mems();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rdy", {30'd0, ia.rdy, ib.rdy}, 32'd3);
      chk("reset_invalid", {30'd0, ia.invalid, ib.invalid}, 32'd0);
      chk("reset_wren", {30'd0, s_wren, pt_wren}, 32'd0);
      chk("reset_addrs", {s_addr, ct_addr, pt_addr, s_wrdata | pt_wrdata}, 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // zero length
      set_identity();
      run_case(1'b0, "zero_len", 0);
      chk("zero_len_lat", last_lat, 4);
      chk("zero_len_swren", s_wr_cnt, 0);
      chk("zero_len_pt0", {pt_written[0], pt_mem[0]}, {1'b1, 8'h00});

      // identity S, "CGD"
      set_identity();
      ct_init[0] = 8'h03; ct_init[1] = 8'h41; ct_init[2] = 8'h42; ct_init[3] = 8'h43;
      run_case(1'b0, "cgd", 0);
      check_scn2("cgd");

      // early abort
      set_identity();
      ct_init[0] = 8'h03; ct_init[1] = 8'h02; ct_init[2] = 8'h41; ct_init[3] = 8'h41;
      run_case(1'b0, "abort", 0);
      chk("abort_pt0", pt_mem[0], 8'h03);
      chk("abort_pt1", pt_mem[1], 8'h00);
      chk("abort_unwritten", {30'd0, pt_written[2], pt_written[3]}, 32'd0);
      chk("abort_lat", last_lat, 13);
      chk("abort_inv", {31'd0, ia.invalid}, 32'd1);

      // same stimulus, no abort
      run_case(1'b1, "noabort", 0);
      chk("noabort_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03004446);
      chk("noabort_lat", last_lat, 31);
      repeat (3) @(posedge clk);
      #1;
      chk("noabort_inv_hold", {31'd0, ib.invalid}, 32'd1);

      // en pulsed while busy
      set_identity();
      ct_init[0] = 8'h03; ct_init[1] = 8'h41; ct_init[2] = 8'h42; ct_init[3] = 8'h43;
      run_case(1'b0, "busy_en", 5);
      check_scn2("busy_en");

      // reset landing in WR_SJ (second S write of the first byte)
      load_mems();
      exp_q.delete();
      model(1'b1);
      s_wr_cnt = 0;
      @(negedge clk);
      ia.en = 1'b1;
      @(posedge clk);
      #1;
      ia.en = 1'b0;
      n = 0;
      while (s_wr_cnt < 2 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reached_wr_sj", {31'd0, s_wr_cnt == 2}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_rdy", {31'd0, ia.rdy}, 32'd1);
      chk("rst_mid_wren", {30'd0, s_wren, pt_wren}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_idle", {30'd0, ia.rdy, ia.invalid}, 32'd2);
      exp_q.delete();
      set_identity();
      ct_init[0] = 8'h03; ct_init[1] = 8'h41; ct_init[2] = 8'h42; ct_init[3] = 8'h43;
      run_case(1'b0, "after_rst", 0);
      check_scn2("after_rst");

      // randomized short runs on both instances
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(0, 12);
         set_random(len);
         // bias some bytes toward printable plaintext is not needed; aborts
         // are exercised whenever a bad byte appears
         run_case(r[0], $sformatf("rand%0d", r), 0);
      end

      // full-length wrap
      set_random(255);
      run_case(1'b1, "wrap", 0);
      chk("wrap_lat", last_lat, 2299);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
